// File: rtl/noise_loader_pkg.sv
// noise_loader_pkg: shared state encoding, error bit positions and default sizes
// for the noise CDF table loader.
package noise_loader_pkg;
    typedef enum logic [2:0] {IDLE, READ, DRAIN, WAIT_ACK, RUN, ERR} ldr_state_t;
    localparam int ERR_TIMEOUT = 0;
    localparam int ERR_MONO = 1;
    localparam int DEF_TABLE_DEPTH = 128;
    localparam int DEF_DATA_W = 64;
endpackage

// File: rtl/noise_rd_pipe.sv
// noise_rd_pipe: RD_LAT-deep valid/index shift register that lines up each table
// RAM read with the data returning RD_LAT cycles later.
//   clk, rst     clock, synchronous active-high reset
//   flush        drop every read in flight (including the one entering this cycle)
//   rd_valid     read strobe issued this cycle
//   rd_idx       entry index of that read
//   beat_valid   tbl_rd_data currently holds the data of a tracked read
//   beat_idx     entry index belonging to that data
//   busy         any read still in flight
module noise_rd_pipe #(
    parameter int RD_LAT = 1,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          rd_valid,
    input  logic [AW-1:0] rd_idx,
    output logic          beat_valid,
    output logic [AW-1:0] beat_idx,
    output logic          busy
);
    logic [RD_LAT-1:0] v;
    logic [AW-1:0]     idx [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            v <= '0;
        end else begin
            v[0] <= rd_valid;
            for (int i = 1; i < RD_LAT; i++) v[i] <= v[i-1];
        end
        idx[0] <= rd_idx;
        for (int i = 1; i < RD_LAT; i++) idx[i] <= idx[i-1];
    end

    assign beat_valid = v[RD_LAT-1];
    assign beat_idx = idx[RD_LAT-1];
    assign busy = |v;
endmodule

// File: rtl/noise_table_loader.sv
// noise_table_loader: streams TABLE_DEPTH CDF thresholds (plus PAD_BEATS repeats of
// the last one) from the table RAM into the noise generator load port, waits for the
// generator's done, then gates its enable.
//   clk, rst                 clock, synchronous active-high reset
//   start                    (re)load pulse, honoured in IDLE, RUN and ERR
//   run_req                  user wants samples while RUN
//   tbl_rd_en/addr/data      table RAM read port, data valid RD_LAT cycles after en
//   noise_load_mem/location/mem_data  load beats to the generator
//   noise_done               generator done_wait
//   noise_en                 generator enable (RUN only)
//   busy, ready              READ/DRAIN/WAIT_ACK, RUN
//   err                      sticky [0] ack timeout, [1] non-monotonic CDF
// Optional: NOISE_LOADER_MONO_CHECK_EN enables the CDF monotonicity check.
module noise_table_loader import noise_loader_pkg::*; #(
    parameter int TABLE_DEPTH = DEF_TABLE_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1,
    parameter int PAD_BEATS = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           run_req,
    output logic                           tbl_rd_en,
    output logic [$clog2(TABLE_DEPTH)-1:0] tbl_rd_addr,
    input  logic [DATA_W-1:0]              tbl_rd_data,
    output logic                           noise_load_mem,
    output logic [7:0]                     noise_location,
    output logic [DATA_W-1:0]              noise_mem_data,
    input  logic                           noise_done,
    output logic                           noise_en,
    output logic                           busy,
    output logic                           ready,
    output logic [1:0]                     err
);
    localparam int AW = $clog2(TABLE_DEPTH);
    localparam int TOTAL = TABLE_DEPTH + PAD_BEATS;
    localparam int CW = $clog2(TOTAL + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    ldr_state_t    state;
    logic [CW-1:0] rd_cnt;
    logic [TW-1:0] wait_cnt;
    logic          beat_valid;
    logic [AW-1:0] beat_idx;
    logic          pipe_busy;
    logic          mono_fail;

`ifdef NOISE_LOADER_MONO_CHECK_EN
    // The output registers hold the previous beat; a held location of TABLE_DEPTH-1
    // means the incoming beat is a pad, which is not checked.
    assign mono_fail = beat_valid && beat_idx != '0 && noise_location != 8'(TABLE_DEPTH - 1)
                       && tbl_rd_data < noise_mem_data;
`else
    assign mono_fail = 1'b0;
`endif

    noise_rd_pipe #(.RD_LAT(RD_LAT), .AW(AW)) u_pipe (
        .clk        (clk),
        .rst        (rst),
        .flush      (mono_fail),
        .rd_valid   (tbl_rd_en),
        .rd_idx     (tbl_rd_addr),
        .beat_valid (beat_valid),
        .beat_idx   (beat_idx),
        .busy       (pipe_busy)
    );

    assign busy = state == READ || state == DRAIN || state == WAIT_ACK;
    assign ready = state == RUN;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rd_cnt <= '0;
            wait_cnt <= '0;
            tbl_rd_en <= 1'b0;
            tbl_rd_addr <= '0;
            noise_load_mem <= 1'b0;
            noise_location <= '0;
            noise_mem_data <= '0;
            noise_en <= 1'b0;
            err <= '0;
        end else begin
            noise_load_mem <= beat_valid;
            if (beat_valid) begin
                noise_location <= 8'(beat_idx);
                noise_mem_data <= tbl_rd_data;
            end
            noise_en <= state == RUN && run_req && !start;
            case (state)
                IDLE, RUN, ERR: begin
                    if (start) begin
                        state <= READ;
                        tbl_rd_en <= 1'b1;
                        tbl_rd_addr <= '0;
                        rd_cnt <= CW'(1);
                        err <= '0;
                    end
                end
                READ: begin
                    // rd_cnt counts reads already issued; past the table it keeps
                    // re-reading the last entry to produce the pad beats.
                    if (rd_cnt == CW'(TOTAL)) begin
                        tbl_rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        tbl_rd_addr <= rd_cnt >= CW'(TABLE_DEPTH) ? AW'(TABLE_DEPTH - 1) : AW'(rd_cnt);
                        rd_cnt <= rd_cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    if (!pipe_busy) begin
                        state <= WAIT_ACK;
                        wait_cnt <= '0;
                    end
                end
                WAIT_ACK: begin
                    if (noise_done) begin
                        state <= RUN;
                    end else if (wait_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        state <= ERR;
                        err[ERR_TIMEOUT] <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
            // Abort: stop reading, in-flight reads are flushed in the pipe.
            if (mono_fail) begin
                state <= ERR;
                tbl_rd_en <= 1'b0;
                err[ERR_MONO] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_noise_table_loader.sv
// tb_noise_table_loader: randomized self-checking bench for noise_table_loader.
module tb_noise_table_loader;
    localparam int TD = 128;
    localparam int NB = 130;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic run_req = 1'b0;
    logic noise_done = 1'b0;

    logic        rd_en_a, lm_a, en_a, busy_a, ready_a;
    logic [6:0]  rd_addr_a;
    logic [63:0] rd_data_a, md_a;
    logic [7:0]  loc_a;
    logic [1:0]  err_a;
    logic        rd_en_b, lm_b, en_b, busy_b, ready_b;
    logic [6:0]  rd_addr_b;
    logic [63:0] rd_data_b, md_b;
    logic [7:0]  loc_b;
    logic [1:0]  err_b;

    logic [63:0] ram [TD];
    logic [63:0] b_s [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int inv_bad = 0;
    int lb;

    int          bq_cyc[$];
    logic [7:0]  bq_loc[$];
    logic [63:0] bq_data[$];
    logic [1:0]  bq_err[$];
    int          rdq_a[$];
    int          bq_cycb[$];
    logic [7:0]  bq_locb[$];
    int          rdq_b[$];

    always #5 clk = ~clk;

    noise_table_loader #(.RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .run_req(run_req),
        .tbl_rd_en(rd_en_a), .tbl_rd_addr(rd_addr_a), .tbl_rd_data(rd_data_a),
        .noise_load_mem(lm_a), .noise_location(loc_a), .noise_mem_data(md_a),
        .noise_done(noise_done), .noise_en(en_a), .busy(busy_a), .ready(ready_a), .err(err_a)
    );

    noise_table_loader #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .run_req(run_req),
        .tbl_rd_en(rd_en_b), .tbl_rd_addr(rd_addr_b), .tbl_rd_data(rd_data_b),
        .noise_load_mem(lm_b), .noise_location(loc_b), .noise_mem_data(md_b),
        .noise_done(noise_done), .noise_en(en_b), .busy(busy_b), .ready(ready_b), .err(err_b)
    );

    // Table RAMs: garbage on cycles without a read so stray samples are visible.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd_data_a <= rd_en_a ? ram[rd_addr_a] : {$urandom, $urandom};
        b_s[0] <= rd_en_b ? ram[rd_addr_b] : {$urandom, $urandom};
        b_s[1] <= b_s[0];
        rd_data_b <= b_s[1];
    end

    always @(negedge clk) begin
        if (lm_a) begin
            bq_cyc.push_back(cyc);
            bq_loc.push_back(loc_a);
            bq_data.push_back(md_a);
            bq_err.push_back(err_a);
        end
        if (rd_en_a) rdq_a.push_back(cyc);
        if (lm_b) begin
            bq_cycb.push_back(cyc);
            bq_locb.push_back(loc_b);
        end
        if (rd_en_b) rdq_b.push_back(cyc);
        if (en_a && (lm_a || busy_a)) inv_bad <= inv_bad + 1;
    end

    // Reference: beat i carries entry min(i, TD-1) of the table, one beat per cycle.
    function automatic int stream_diff(input int n);
        int d = 0;
        if (bq_loc.size() != n) return 1000 + bq_loc.size();
        for (int i = 0; i < n; i++) begin
            int e = (i < TD) ? i : TD - 1;
            if (bq_loc[i] != 8'(e) || bq_data[i] != ram[e] || bq_cyc[i] != bq_cyc[0] + i) d++;
        end
        return d;
    endfunction

    function automatic int first_lat(input int q_rd[$], input int q_bt[$]);
        if (q_rd.size() == 0 || q_bt.size() == 0) return -1;
        return q_bt[0] - q_rd[0];
    endfunction

    task automatic fill_ram_mono;
        ram[0] = {32'h0, $urandom};
        for (int k = 1; k < TD; k++) ram[k] = ram[k-1] + 64'($urandom_range(1, 1 << 20));
    endtask

    task automatic pulse_start;
        bq_cyc.delete(); bq_loc.delete(); bq_data.delete(); bq_err.delete();
        rdq_a.delete(); bq_cycb.delete(); bq_locb.delete(); rdq_b.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_beats(input int n, output int last);
        for (int k = 0; k < 400 && bq_loc.size() < n; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        last = bq_cyc.size() > 0 ? bq_cyc[$] : -1;
    endtask

    task automatic wait_until(input int c);
        for (int k = 0; k < 1000 && cyc < c; k++) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({rd_en_a, rd_addr_a, lm_a, loc_a, md_a, en_a, busy_a, ready_a, err_a} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, expected 0",
                     {rd_en_a, rd_addr_a, lm_a, loc_a, md_a, en_a, busy_a, ready_a, err_a});
        end
        rst = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_a, rd_en_a, lm_a} !== 3'b000) begin
            errors++;
            $display("FAIL reset_start_ignored: busy/rd_en/load=%b, expected 000", {busy_a, rd_en_a, lm_a});
        end
    endtask

    task automatic test_load;
        int d;
        for (int k = 0; k < TD; k++) ram[k] = 64'(k) << 49;
        pulse_start();
        checks++;
        if ({busy_a, rd_en_a, rd_addr_a} !== {2'b11, 7'd0}) begin
            errors++;
            $display("FAIL load_first_read: busy/rd_en/addr=%b, expected 110000000", {busy_a, rd_en_a, rd_addr_a});
        end
        wait_beats(NB, lb);
        d = stream_diff(NB);
        checks++;
        if (d !== 0) begin
            errors++;
            $display("FAIL load_stream: %0d bad beats (count %0d), expected 0 bad of %0d", d, bq_loc.size(), NB);
        end
        checks++;
        if (first_lat(rdq_a, bq_cyc) !== 2) begin
            errors++;
            $display("FAIL load_latency: first beat %0d cycles after first read, expected 2", first_lat(rdq_a, bq_cyc));
        end
        checks++;
        if ({lm_a, busy_a, ready_a} !== 3'b010) begin
            errors++;
            $display("FAIL load_wait_ack: load/busy/ready=%b, expected 010", {lm_a, busy_a, ready_a});
        end
        wait_until(lb + 5);
        noise_done = 1'b1;
        run_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({ready_a, busy_a, en_a} !== 3'b100) begin
            errors++;
            $display("FAIL run_entry: ready/busy/en=%b, expected 100", {ready_a, busy_a, en_a});
        end
        @(negedge clk);
        checks++;
        if (en_a !== 1'b1) begin
            errors++;
            $display("FAIL run_enable: noise_en=%b, expected 1", en_a);
        end
        noise_done = 1'b0;
    endtask

    task automatic test_reload_in_run;
        int d;
        fill_ram_mono();
        repeat (3) @(negedge clk);
        pulse_start();
        checks++;
        if ({en_a, busy_a, ready_a} !== 3'b010) begin
            errors++;
            $display("FAIL reload_drop_en: en/busy/ready=%b, expected 010", {en_a, busy_a, ready_a});
        end
        wait_beats(NB, lb);
        d = stream_diff(NB);
        checks++;
        if (d !== 0) begin
            errors++;
            $display("FAIL reload_stream: %0d bad beats (count %0d), expected 0", d, bq_loc.size());
        end
        noise_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({ready_a, en_a} !== 2'b11) begin
            errors++;
            $display("FAIL reload_run_again: ready/en=%b, expected 11", {ready_a, en_a});
        end
        noise_done = 1'b0;
    endtask

    task automatic test_timeout;
        int d;
        fill_ram_mono();
        repeat (3) @(negedge clk);
        pulse_start();
        wait_beats(NB, lb);
        d = stream_diff(NB);
        checks++;
        if (d !== 0) begin
            errors++;
            $display("FAIL timeout_stream: %0d bad beats, expected 0", d);
        end
        wait_until(lb + 255);
        checks++;
        if ({busy_a, err_a} !== 3'b100) begin
            errors++;
            $display("FAIL timeout_early: busy/err=%b at 254 cycles into WAIT_ACK, expected 100", {busy_a, err_a});
        end
        @(negedge clk);
        checks++;
        if ({busy_a, ready_a, en_a, err_a} !== 5'b00001) begin
            errors++;
            $display("FAIL timeout_err: busy/ready/en/err=%b, expected 00001", {busy_a, ready_a, en_a, err_a});
        end
        repeat (5) @(negedge clk);
        fill_ram_mono();
        pulse_start();
        checks++;
        if ({busy_a, err_a} !== 3'b100) begin
            errors++;
            $display("FAIL timeout_restart: busy/err=%b, expected 100", {busy_a, err_a});
        end
        wait_beats(NB, lb);
        d = stream_diff(NB);
        checks++;
        if (d !== 0) begin
            errors++;
            $display("FAIL timeout_reload_stream: %0d bad beats, expected 0", d);
        end
        noise_done = 1'b1;
        @(negedge clk);
        checks++;
        if ({ready_a, err_a} !== 3'b100) begin
            errors++;
            $display("FAIL timeout_recover: ready/err=%b, expected 100", {ready_a, err_a});
        end
        noise_done = 1'b0;
        run_req = 1'b0;
    endtask

    task automatic test_mono;
        int d;
        fill_ram_mono();
        ram[40] = ram[39] - 64'd1;
        repeat (5) @(negedge clk);
        pulse_start();
`ifdef NOISE_LOADER_MONO_CHECK_EN
        wait_beats(41, lb);
        repeat (10) @(negedge clk);
        d = stream_diff(41);
        checks++;
        if (d !== 0) begin
            errors++;
            $display("FAIL mono_stream: %0d bad beats (count %0d), expected 41 clean beats", d, bq_loc.size());
        end
        checks++;
        if (bq_err.size() != 41 || bq_err[40] !== 2'b10 || bq_err[39] !== 2'b00) begin
            errors++;
            $display("FAIL mono_err_beat: beats=%0d, expected err 10 on beat 40 and 00 on beat 39", bq_err.size());
        end
        checks++;
        if ({busy_a, ready_a, en_a, err_a} !== 5'b00010) begin
            errors++;
            $display("FAIL mono_err_state: busy/ready/en/err=%b, expected 00010", {busy_a, ready_a, en_a, err_a});
        end
`else
        wait_beats(NB, lb);
        d = stream_diff(NB);
        checks++;
        if (d !== 0) begin
            errors++;
            $display("FAIL nomono_stream: %0d bad beats (count %0d), expected 0", d, bq_loc.size());
        end
        noise_done = 1'b1;
        @(negedge clk);
        checks++;
        if ({ready_a, err_a} !== 3'b100) begin
            errors++;
            $display("FAIL nomono_run: ready/err=%b, expected 100", {ready_a, err_a});
        end
        noise_done = 1'b0;
`endif
    endtask

    task automatic test_rst_rdlat;
        int n, d;
        bit hit = 0;
        fill_ram_mono();
        repeat (5) @(negedge clk);
        pulse_start();
        for (int k = 0; k < 200 && !hit; k++) begin
            if (lm_a && loc_a == 8'd64) hit = 1;
            else @(negedge clk);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rst_reach_beat64: beat 64 seen=%0d, expected 1", hit);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({rd_en_a, rd_addr_a, lm_a, loc_a, md_a, en_a, busy_a, ready_a, err_a} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %h, expected 0",
                     {rd_en_a, rd_addr_a, lm_a, loc_a, md_a, en_a, busy_a, ready_a, err_a});
        end
        rst = 1'b0;
        n = bq_loc.size();
        repeat (10) @(negedge clk);
        checks++;
        if (bq_loc.size() !== n || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle: %0d extra beats, busy=%b, expected 0 and 0", bq_loc.size() - n, busy_a);
        end
        pulse_start();
        wait_beats(NB, lb);
        repeat (4) @(negedge clk);
        checks++;
        if (first_lat(rdq_b, bq_cycb) !== 4) begin
            errors++;
            $display("FAIL rdlat3_latency: first beat %0d cycles after first read, expected 4", first_lat(rdq_b, bq_cycb));
        end
        d = 0;
        if (bq_locb.size() != NB) d = 1000 + bq_locb.size();
        else for (int i = 0; i < NB; i++)
            if (bq_locb[i] != 8'((i < TD) ? i : TD - 1) || bq_cycb[i] != bq_cycb[0] + i) d++;
        checks++;
        if (d !== 0) begin
            errors++;
            $display("FAIL rdlat3_stream: %0d bad beats (count %0d), expected 0", d, bq_locb.size());
        end
        d = stream_diff(NB);
        checks++;
        if (d !== 0) begin
            errors++;
            $display("FAIL rst_reload_stream: %0d bad beats, expected 0", d);
        end
    endtask

    task automatic test_invariant;
        checks++;
        if (inv_bad !== 0) begin
            errors++;
            $display("FAIL en_overlap: %0d cycles with noise_en during load/busy, expected 0", inv_bad);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_reload_in_run();
        test_timeout();
        test_mono();
        test_rst_rdlat();
        test_invariant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
